contador_universal: RTL and testbench

CONTADOR_UNIVERSAL -- requirements
Module: contador_universal

---
 rtl/contador_pkg.sv | 16 +
 rtl/contador_universal.sv | 54 +++++
 tb/tb_contador_universal.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/contador_pkg.sv
// contador_pkg: shared direction constants and the priority-action encoding for contador_universal
package contador_pkg;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    localparam logic [1:0] HOLD = 2'd0;
    localparam logic [1:0] CLR  = 2'd1;
    localparam logic [1:0] LOAD = 2'd2;
    localparam logic [1:0] CNT  = 2'd3;

    function automatic logic [1:0] pick_action(input logic sclr, input logic load, input logic en);
        return sclr ? CLR : load ? LOAD : en ? CNT : HOLD;
    endfunction

endpackage

// File: rtl/contador_universal.sv
// contador_universal: cascadable up/down modulo counter with sync clear, parallel load and terminal count.
// Define CONTADOR_UNIVERSAL_SAT_EN to saturate at the range ends instead of wrapping.
module contador_universal
    import contador_pkg::*;
#(
    parameter int               WIDTH   = 4,
    parameter logic [WIDTH-1:0] MOD_MAX = {WIDTH{1'b1}}
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             sclr,
    input  logic             load,
    input  logic [WIDTH-1:0] DATA,
    input  logic             enp,
    input  logic             ent,
    input  logic             up,
    output logic [WIDTH-1:0] Q,
    output logic             tc,
    output logic             wrap
);

    logic [1:0]       action;
    logic             hit;
    logic             wrap_evt;
    logic [WIDTH-1:0] q_step;
    logic [WIDTH-1:0] q_next;

    // hit marks the range end in the current direction; Q above MOD_MAX counts as the top
    always_comb begin
        action = pick_action(sclr, load, enp & ent);
        hit    = (up == DIR_UP) ? (Q >= MOD_MAX) : (Q == '0);
`ifdef CONTADOR_UNIVERSAL_SAT_EN
        q_step   = hit ? Q : (up == DIR_UP) ? Q + 1'b1 : Q - 1'b1;
        wrap_evt = 1'b0;
`else
        q_step   = (up == DIR_UP) ? (hit ? '0 : Q + 1'b1) : (hit ? MOD_MAX : Q - 1'b1);
        wrap_evt = (action == CNT) & hit;
`endif
        q_next = (action == CLR) ? '0 : (action == LOAD) ? DATA : (action == CNT) ? q_step : Q;
    end

    assign tc = ent & hit;

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            Q    <= '0;
            wrap <= 1'b0;
        end else begin
            Q    <= q_next;
            wrap <= wrap_evt;
        end
    end

endmodule

// File: tb/tb_contador_universal.sv
// tb_contador_universal: scoreboard bench for a MOD_MAX=9 counter plus a two-stage MOD_MAX=15 cascade
module tb_contador_universal;

    localparam int MAXV = 9;
`ifdef CONTADOR_UNIVERSAL_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       clear = 1'b1;
    logic       sclr = 1'b0, load = 1'b0, enp = 1'b0, ent = 1'b0, up = 1'b1;
    logic [3:0] DATA = '0;
    logic [3:0] Q;
    logic       tc, wrap;

    logic       c_load = 1'b0, c_enp = 1'b0, c_ent = 1'b0, c_up = 1'b1, hi_en = 1'b1;
    logic [7:0] c_data = '0;
    logic [3:0] lo_q, hi_q;
    logic       lo_tc, hi_tc, lo_wrap, hi_wrap;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int q;
        bit w;
        bit t;
        int c;
    } exp_t;
    exp_t sb[$];

    int m_q = 0;
    int m_lo = 0;
    int m_hi = 0;

    always #5 clock = ~clock;

    contador_universal #(.WIDTH(4), .MOD_MAX(4'd9)) dut (
        .clock(clock), .clear(clear), .sclr(sclr), .load(load), .DATA(DATA),
        .enp(enp), .ent(ent), .up(up), .Q(Q), .tc(tc), .wrap(wrap)
    );

    contador_universal #(.WIDTH(4), .MOD_MAX(4'd15)) stage0 (
        .clock(clock), .clear(clear), .sclr(1'b0), .load(c_load), .DATA(c_data[3:0]),
        .enp(c_enp), .ent(c_ent), .up(c_up), .Q(lo_q), .tc(lo_tc), .wrap(lo_wrap)
    );

    contador_universal #(.WIDTH(4), .MOD_MAX(4'd15)) stage1 (
        .clock(clock), .clear(clear), .sclr(1'b0), .load(c_load), .DATA(c_data[7:4]),
        .enp(c_enp), .ent(lo_tc & hi_en), .up(c_up), .Q(hi_q), .tc(hi_tc), .wrap(hi_wrap)
    );

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    // one 4-bit cascade stage counting over the full 0..15 range
    function automatic int nib(input int v, input bit dir);
        if (dir) return (v == 15) ? (SAT ? 15 : 0) : v + 1;
        return (v == 0) ? (SAT ? 0 : 15) : v - 1;
    endfunction

    // drive one edge's inputs at the falling edge and queue what must be seen after the rising edge
    task automatic step(input bit s, input bit l, input int d, input bit ep, input bit et, input bit u,
                        input bit cl = 0, input int cd = 0, input bit cep = 0, input bit cet = 0,
                        input bit cu = 1, input bit he = 1);
        exp_t e;
        bit   carry;
        @(negedge clock);
        sclr = s; load = l; DATA = 4'(d); enp = ep; ent = et; up = u;
        c_load = cl; c_data = 8'(cd); c_enp = cep; c_ent = cet; c_up = cu; hi_en = he;
        e.w = 1'b0;
        if (s) m_q = 0;
        else if (l) m_q = d;
        else if (ep && et) begin
            if (u && m_q >= MAXV) begin
                m_q = SAT ? m_q : 0;
                e.w = !SAT;
            end else if (!u && m_q == 0) begin
                m_q = SAT ? 0 : MAXV;
                e.w = !SAT;
            end else m_q = u ? m_q + 1 : m_q - 1;
        end
        e.q = m_q;
        e.t = et && (u ? (m_q >= MAXV) : (m_q == 0));
        carry = cep && cet && he && (cu ? (m_lo == 15) : (m_lo == 0));
        if (cl) begin
            m_lo = cd % 16;
            m_hi = cd / 16;
        end else begin
            if (cep && cet) m_lo = nib(m_lo, cu);
            if (carry) m_hi = nib(m_hi, cu);
        end
        e.c = m_hi * 16 + m_lo;
        sb.push_back(e);
    endtask

    task automatic pulse_clear();
        @(negedge clock);
        sclr = 0; load = 0; enp = 0; ent = 0; c_load = 0; c_enp = 0; c_ent = 0;
        #2 clear = 1'b1;
        #1;
        check("clear_q", int'(Q), 0);
        check("clear_wrap", int'(wrap), 0);
        check("clear_casc", int'({hi_q, lo_q}), 0);
        clear = 1'b0;
        m_q = 0; m_lo = 0; m_hi = 0;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("q", int'(Q), e.q);
                check("wrap", int'(wrap), int'(e.w));
                check("tc", int'(tc), int'(e.t));
                check("cascade", int'({hi_q, lo_q}), e.c);
            end
        end
    end

    initial begin : stimulus
        #3;
        check("reset_q", int'(Q), 0);
        check("reset_wrap", int'(wrap), 0);
        check("reset_tc", int'(tc), 0);
        ent = 1'b1;
        up = 1'b0;
        #1 check("reset_tc_down", int'(tc), 1);
        clear = 1'b0;
        for (int i = 0; i < 12; i++) step(0, 0, 0, 1, 1, 1);
        step(0, 1, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 1, 0);
        step(1, 1, 5, 1, 1, 1);
        step(0, 1, 5, 0, 0, 1);
        step(0, 1, 3, 1, 1, 1);
        step(0, 1, 13, 0, 0, 1);
        step(0, 0, 0, 1, 1, 1);
        step(0, 0, 0, 1, 0, 1);
        step(0, 1, 13, 0, 0, 0);
        step(0, 0, 0, 1, 1, 0);
        step(0, 1, 7, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1);
        pulse_clear();
        step(0, 0, 0, 1, 1, 1);
        step(0, 0, 0, 0, 0, 1, 1, 8'h0F);
        step(0, 0, 0, 0, 0, 1, 0, 0, 1, 1, 1, 1);
        step(0, 0, 0, 0, 0, 1, 1, 8'h1F);
        step(0, 0, 0, 0, 0, 1, 0, 0, 1, 1, 1, 0);
        step(0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 1, 1);
        step(0, 0, 0, 0, 0, 1, 1, 8'h20);
        step(0, 0, 0, 0, 0, 1, 0, 0, 1, 1, 0, 1);
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 49) == 0) pulse_clear();
            step($urandom_range(0, 15) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 15),
                 $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 1),
                 $urandom_range(0, 15) == 0, $urandom_range(0, 255),
                 $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 1),
                 $urandom_range(0, 5) != 0);
        end
        for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clock);
        #3;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
